// File: rtl/kalman_mm_sched.sv
// Round-robin scheduler sharing one matrix-multiply engine between N_REQ Kalman requesters.
// Optional busy watchdog with mm_abort_o: define KALMAN_MM_TIMEOUT_EN.
module kalman_mm_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MAX_DIM = 4,
  parameter int unsigned DIM_W   = $clog2(MAX_DIM) + 1,
  parameter int unsigned AW      = 8,
  parameter int unsigned DATA_W  = 16
`ifdef KALMAN_MM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 1023
`endif
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*DIM_W-1:0]   req_col_i,
  input  logic [N_REQ*DIM_W-1:0]   req_row0_i,
  input  logic [N_REQ*DIM_W-1:0]   req_row1_i,
  input  logic [N_REQ*AW-1:0]      req_base_a_i,
  input  logic [N_REQ*AW-1:0]      req_base_b_i,
  input  logic [N_REQ*AW-1:0]      req_base_r_i,
  output logic [N_REQ-1:0]         done_o,
  output logic                     busy_o,
  output logic [N_REQ-1:0]         gnt_o,
  output logic                     mm_start_o,
  output logic [DIM_W-1:0]         mm_col_o,
  output logic [DIM_W-1:0]         mm_row0_o,
  output logic [DIM_W-1:0]         mm_row1_o,
  input  logic [DIM_W-1:0]         mm_cnt_a_i,
  input  logic [DIM_W-1:0]         mm_cnt_b_i,
  input  logic [DIM_W-1:0]         mm_cnt_c_i,
  input  logic                     mm_data_v_i,
  input  logic [DATA_W-1:0]        mm_data_i,
  input  logic                     mm_finish_i,
  output logic [AW-1:0]            addr_a_o,
  output logic [AW-1:0]            addr_b_o,
  output logic                     wr_en_o,
  output logic [AW-1:0]            wr_addr_o,
  output logic [DATA_W-1:0]        wr_data_o,
`ifdef KALMAN_MM_TIMEOUT_EN
  output logic                     mm_abort_o,
`endif
  output logic                     err_o
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned IDX_W = 2 * DIM_W;
`ifdef KALMAN_MM_TIMEOUT_EN
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [DIM_W-1:0]   col_q, col_d, row0_q, row0_d, row1_q, row1_d;
  logic [AW-1:0]      base_a_q, base_a_d, base_b_q, base_b_d, base_r_q, base_r_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [N_REQ-1:0]   gnt_d, done_d;
  logic               busy_d, start_d, err_d, wr_en_d;
  logic [AW-1:0]      wr_addr_d;
  logic [DATA_W-1:0]  wr_data_d;
`ifdef KALMAN_MM_TIMEOUT_EN
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               abort_d;
`endif

  logic               found;
  logic [PTR_W-1:0]   sel;
  int unsigned        idx;
  logic [DIM_W-1:0]   cand_col, cand_row0, cand_row1;
  logic               cand_zero;
  logic [IDX_W-1:0]   wr_cnt_final;
  logic [IDX_W-1:0]   wr_expect;

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  // First pending requester strictly after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

  assign cand_col  = req_col_i[int'(sel)*DIM_W +: DIM_W];
  assign cand_row0 = req_row0_i[int'(sel)*DIM_W +: DIM_W];
  assign cand_row1 = req_row1_i[int'(sel)*DIM_W +: DIM_W];
  assign cand_zero = (cand_col == '0) || (cand_row0 == '0) || (cand_row1 == '0);

  // Writes seen so far including one landing in the finish cycle.
  assign wr_cnt_final = wr_idx_q + IDX_W'(mm_data_v_i);
  assign wr_expect    = IDX_W'(col_q) * IDX_W'(row1_q);

  // Operand addresses follow the engine counters; wrap modulo 2^AW.
  assign addr_a_o = base_a_q + AW'(mm_cnt_c_i) * AW'(row0_q) + AW'(mm_cnt_a_i);
  assign addr_b_o = base_b_q + AW'(mm_cnt_a_i) * AW'(row1_q) + AW'(mm_cnt_b_i);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    col_d     = col_q;
    row0_d    = row0_q;
    row1_d    = row1_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    base_r_d  = base_r_q;
    wr_idx_d  = wr_idx_q;
    gnt_d     = gnt_o;
    done_d    = '0;
    err_d     = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_o;
    wr_data_d = wr_data_o;
`ifdef KALMAN_MM_TIMEOUT_EN
    wdog_d    = wdog_q;
    abort_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req_i) state_d = ARB;
      end
      ARB: begin
        if (found) begin
          owner_d  = sel;
          col_d    = cand_col;
          row0_d   = cand_row0;
          row1_d   = cand_row1;
          base_a_d = req_base_a_i[int'(sel)*AW +: AW];
          base_b_d = req_base_b_i[int'(sel)*AW +: AW];
          base_r_d = req_base_r_i[int'(sel)*AW +: AW];
          wr_idx_d = '0;
          gnt_d    = onehot(sel);
          if (cand_zero) begin
            done_d  = onehot(sel);
            err_d   = 1'b1;
            ptr_d   = sel;
            state_d = IDLE;
          end else begin
            state_d = START;
          end
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = BUSY;
`ifdef KALMAN_MM_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      BUSY: begin
        if (mm_data_v_i) begin
          wr_en_d   = 1'b1;
          wr_data_d = mm_data_i;
          wr_addr_d = base_r_q + AW'(wr_idx_q);
          wr_idx_d  = wr_idx_q + IDX_W'(1);
        end
        if (mm_finish_i) begin
          done_d  = onehot(owner_q);
          err_d   = (wr_cnt_final != wr_expect);
          state_d = DONE;
        end
`ifdef KALMAN_MM_TIMEOUT_EN
        else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          done_d  = onehot(owner_q);
          err_d   = 1'b1;
          abort_d = 1'b1;
          gnt_d   = '0;
          ptr_d   = owner_q;
          state_d = IDLE;
        end else begin
          wdog_d  = wdog_q + WD_W'(1);
        end
`endif
      end
      DONE: begin
        gnt_d   = '0;
        ptr_d   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == START) || (state_d == BUSY) || (state_d == DONE);
    start_d = (state_d == START) && (state_q == ARB);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      col_q      <= '0;
      row0_q     <= '0;
      row1_q     <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      base_r_q   <= '0;
      wr_idx_q   <= '0;
      gnt_o      <= '0;
      done_o     <= '0;
      busy_o     <= 1'b0;
      mm_start_o <= 1'b0;
      err_o      <= 1'b0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
`ifdef KALMAN_MM_TIMEOUT_EN
      wdog_q     <= '0;
      mm_abort_o <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      col_q      <= col_d;
      row0_q     <= row0_d;
      row1_q     <= row1_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      base_r_q   <= base_r_d;
      wr_idx_q   <= wr_idx_d;
      gnt_o      <= gnt_d;
      done_o     <= done_d;
      busy_o     <= busy_d;
      mm_start_o <= start_d;
      err_o      <= err_d;
      wr_en_o    <= wr_en_d;
      wr_addr_o  <= wr_addr_d;
      wr_data_o  <= wr_data_d;
`ifdef KALMAN_MM_TIMEOUT_EN
      wdog_q     <= wdog_d;
      mm_abort_o <= abort_d;
`endif
    end
  end

  assign mm_col_o  = col_q;
  assign mm_row0_o = row0_q;
  assign mm_row1_o = row1_q;

endmodule

// File: tb/tb_kalman_mm_sched.sv
// Directed self-checking bench for kalman_mm_sched with a small engine and operand RAM model.
module tb_kalman_mm_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [11:0] req_col_i, req_row0_i, req_row1_i;
  logic [31:0] req_base_a_i, req_base_b_i, req_base_r_i;
  logic [3:0]  done_o, gnt_o;
  logic        busy_o, mm_start_o, err_o, wr_en_o, mm_data_v_i, mm_finish_i;
  logic [2:0]  mm_col_o, mm_row0_o, mm_row1_o, mm_cnt_a_i, mm_cnt_b_i, mm_cnt_c_i;
  logic [15:0] mm_data_i, wr_data_o;
  logic [7:0]  addr_a_o, addr_b_o, wr_addr_o;
`ifdef KALMAN_MM_TIMEOUT_EN
  logic        mm_abort_o;
`endif

  kalman_mm_sched dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i),
    .req_col_i(req_col_i), .req_row0_i(req_row0_i), .req_row1_i(req_row1_i),
    .req_base_a_i(req_base_a_i), .req_base_b_i(req_base_b_i), .req_base_r_i(req_base_r_i),
    .done_o(done_o), .busy_o(busy_o), .gnt_o(gnt_o), .mm_start_o(mm_start_o),
    .mm_col_o(mm_col_o), .mm_row0_o(mm_row0_o), .mm_row1_o(mm_row1_o),
    .mm_cnt_a_i(mm_cnt_a_i), .mm_cnt_b_i(mm_cnt_b_i), .mm_cnt_c_i(mm_cnt_c_i),
    .mm_data_v_i(mm_data_v_i), .mm_data_i(mm_data_i), .mm_finish_i(mm_finish_i),
    .addr_a_o(addr_a_o), .addr_b_o(addr_b_o), .wr_en_o(wr_en_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
`ifdef KALMAN_MM_TIMEOUT_EN
    .mm_abort_o(mm_abort_o),
`endif
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  logic [7:0] ram [256];

  // Passive monitor: logs writes, grants, starts and done/err pulses.
  int n_start = 0, n_done = 0, n_err_done = 0, n_err_alone = 0;
  logic [3:0] last_done = '0, gnt_prev = '0;
  logic [7:0]  wa_q[$];
  logic [15:0] wd_q[$];
  logic [3:0]  glog[$];
  always @(negedge clk_i) begin
    if (mm_start_o) n_start++;
    if (wr_en_o) begin wa_q.push_back(wr_addr_o); wd_q.push_back(wr_data_o); end
    if (done_o != '0) begin n_done++; last_done = done_o; if (err_o) n_err_done++; end
    if (err_o && done_o == '0) n_err_alone++;
    if (gnt_o != '0 && gnt_prev == '0) glog.push_back(gnt_o);
    gnt_prev = gnt_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input int i, input int col, input int row0, input int row1,
                          input int ba, input int bb, input int br);
    req_col_i[i*3 +: 3]    = 3'(col);
    req_row0_i[i*3 +: 3]   = 3'(row0);
    req_row1_i[i*3 +: 3]   = 3'(row1);
    req_base_a_i[i*8 +: 8] = 8'(ba);
    req_base_b_i[i*8 +: 8] = 8'(bb);
    req_base_r_i[i*8 +: 8] = 8'(br);
  endtask

  task automatic wait_start();
    int k = 0;
    while (mm_start_o !== 1'b1 && k < 40) begin @(negedge clk_i); k++; end
    chk("start_seen", 32'(mm_start_o), 32'd1);
  endtask

  // Engine model: reads operands through the DUT addresses, emits each dot product.
  task automatic run_engine(input int col, input int row0, input int row1);
    int unsigned sum;
    wait_start();
    for (int c = 0; c < col; c++)
      for (int b = 0; b < row1; b++) begin
        sum = 0;
        for (int a = 0; a < row0; a++) begin
          @(negedge clk_i);
          mm_cnt_c_i = 3'(c); mm_cnt_a_i = 3'(a); mm_cnt_b_i = 3'(b);
          #1 sum += ram[addr_a_o] * ram[addr_b_o];
        end
        @(negedge clk_i); mm_data_v_i = 1'b1; mm_data_i = 16'(sum);
        @(negedge clk_i); mm_data_v_i = 1'b0;
      end
    mm_finish_i = 1'b1;
    @(negedge clk_i); mm_finish_i = 1'b0;
  endtask

  task automatic emit(input logic [15:0] d);
    @(negedge clk_i); mm_data_v_i = 1'b1; mm_data_i = d;
    @(negedge clk_i); mm_data_v_i = 1'b0;
  endtask

  task automatic finish_job();
    mm_finish_i = 1'b1;
    @(negedge clk_i); mm_finish_i = 1'b0;
  endtask

  int wb, gb, db, sb, eb, ab;
  int k;
  logic [7:0]  exp_a [4];
  logic [15:0] exp_d [4];

  initial begin
    rst_i = 1'b1; req_i = '0;
    req_col_i = '0; req_row0_i = '0; req_row1_i = '0;
    req_base_a_i = '0; req_base_b_i = '0; req_base_r_i = '0;
    mm_cnt_a_i = '0; mm_cnt_b_i = '0; mm_cnt_c_i = '0;
    mm_data_v_i = 1'b0; mm_data_i = '0; mm_finish_i = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i & 7);
    for (int i = 0; i < 6; i++) begin ram[8'h10 + i] = 8'(i + 1); ram[8'h20 + i] = 8'(i + 1); end
    for (int i = 0; i < 4; i++) set_desc(i, 1, 1, 1, 0, 0, 8'h50 + i);
    repeat (3) @(negedge clk_i);
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_start", 32'(mm_start_o), 0);
    chk("rst_wr_en", 32'(wr_en_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_col", 32'(mm_col_o), 0);
    chk("rst_addr_a", 32'(addr_a_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Single 2x3 * 3x2 job on requester 0.
    set_desc(0, 2, 3, 2, 8'h10, 8'h20, 8'h40);
    wb = wa_q.size(); db = n_done; sb = n_start; eb = n_err_done + n_err_alone;
    req_i = 4'b0001;
    run_engine(2, 3, 2);
    req_i = '0;
    @(negedge clk_i); #2;
    exp_a = '{8'h40, 8'h41, 8'h42, 8'h43};
    exp_d = '{16'd22, 16'd28, 16'd49, 16'd64};
    chk("job1_starts", 32'(n_start - sb), 1);
    chk("job1_writes", 32'(wa_q.size() - wb), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("job1_waddr%0d", i), 32'(wa_q[wb + i]), 32'(exp_a[i]));
      chk($sformatf("job1_wdata%0d", i), 32'(wd_q[wb + i]), 32'(exp_d[i]));
    end
    chk("job1_dones", 32'(n_done - db), 1);
    chk("job1_done_vec", 32'(last_done), 32'h1);
    chk("job1_err", 32'(n_err_done + n_err_alone - eb), 0);
    chk("job1_col", 32'(mm_col_o), 2);
    chk("job1_row0", 32'(mm_row0_o), 3);

    // Round-robin with all requesters held.
    set_desc(0, 1, 1, 1, 0, 0, 8'h50);
    gb = glog.size(); db = n_done;
    req_i = 4'b1111;
    for (int j = 0; j < 5; j++) run_engine(1, 1, 1);
    req_i = '0;
    repeat (3) @(negedge clk_i); #2;
    chk("rr_grants", 32'(glog.size() - gb), 5);
    exp_a = '{8'h2, 8'h4, 8'h8, 8'h1};
    for (int j = 0; j < 5; j++) chk($sformatf("rr_gnt%0d", j), 32'(glog[gb + j]), 32'(exp_a[j % 4]));
    chk("rr_dones", 32'(n_done - db), 5);

    // Address generation and full write-back on requester 3.
    set_desc(3, 2, 4, 3, 8'h00, 8'h80, 8'h60);
    wb = wa_q.size(); eb = n_err_done + n_err_alone;
    req_i = 4'b1000;
    wait_start();
    @(negedge clk_i);
    mm_cnt_c_i = 3'd1; mm_cnt_a_i = 3'd2; mm_cnt_b_i = 3'd1;
    #1;
    chk("addr_a", 32'(addr_a_o), 32'h06);
    chk("addr_b", 32'(addr_b_o), 32'h87);
    for (int i = 0; i < 6; i++) emit(16'(100 + i));
    finish_job();
    req_i = '0;
    @(negedge clk_i); #2;
    chk("j3_writes", 32'(wa_q.size() - wb), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("j3_waddr%0d", i), 32'(wa_q[wb + i]), 32'(8'h60 + i));
      chk($sformatf("j3_wdata%0d", i), 32'(wd_q[wb + i]), 32'(100 + i));
    end
    chk("j3_done_vec", 32'(last_done), 32'h8);
    chk("j3_err", 32'(n_err_done + n_err_alone - eb), 0);

    // Short result with wrapping addresses on requester 0.
    set_desc(0, 2, 2, 2, 8'hFE, 8'h00, 8'hFF);
    wb = wa_q.size(); eb = n_err_done; ab = n_err_alone;
    req_i = 4'b0001;
    wait_start();
    @(negedge clk_i);
    mm_cnt_c_i = 3'd1; mm_cnt_a_i = 3'd1; mm_cnt_b_i = 3'd0;
    #1;
    chk("wrap_addr_a", 32'(addr_a_o), 32'h01);
    chk("wrap_addr_b", 32'(addr_b_o), 32'h02);
    emit(16'd7); emit(16'd8); emit(16'd9);
    finish_job();
    req_i = '0;
    @(negedge clk_i); #2;
    chk("short_writes", 32'(wa_q.size() - wb), 3);
    chk("short_waddr0", 32'(wa_q[wb]), 32'hFF);
    chk("short_waddr1", 32'(wa_q[wb + 1]), 32'h00);
    chk("short_waddr2", 32'(wa_q[wb + 2]), 32'h01);
    chk("short_err_with_done", 32'(n_err_done - eb), 1);
    chk("short_err_alone", 32'(n_err_alone - ab), 0);
    chk("short_done_vec", 32'(last_done), 32'h1);

    // Engine strobes outside BUSY are ignored.
    wb = wa_q.size(); db = n_done; eb = n_err_done + n_err_alone;
    @(negedge clk_i); mm_data_v_i = 1'b1; mm_finish_i = 1'b1;
    @(negedge clk_i); mm_data_v_i = 1'b0; mm_finish_i = 1'b0;
    repeat (2) @(negedge clk_i); #2;
    chk("idle_writes", 32'(wa_q.size() - wb), 0);
    chk("idle_dones", 32'(n_done - db), 0);
    chk("idle_err", 32'(n_err_done + n_err_alone - eb), 0);

    // Zero dimension on requester 2.
    set_desc(2, 2, 2, 0, 0, 0, 8'h70);
    wb = wa_q.size(); db = n_done; sb = n_start;
    req_i = 4'b0100;
    k = 0;
    while (done_o == '0 && k < 20) begin @(negedge clk_i); k++; end
    chk("zero_done", 32'(done_o), 32'h4);
    chk("zero_err", 32'(err_o), 1);
    req_i = '0;
    repeat (4) @(negedge clk_i); #2;
    chk("zero_starts", 32'(n_start - sb), 0);
    chk("zero_writes", 32'(wa_q.size() - wb), 0);
    chk("zero_dones", 32'(n_done - db), 1);

    // Reset mid-BUSY, then re-grant of the still-pending requester 1.
    req_i = 4'b0010;
    wait_start();
    emit(16'h55);
    #1 chk("pre_rst_wr_en", 32'(wr_en_o), 1);
    @(negedge clk_i); rst_i = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_wr_en", 32'(wr_en_o), 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    db = n_done; eb = n_err_done + n_err_alone;
    run_engine(1, 1, 1);
    req_i = '0;
    @(negedge clk_i); #2;
    chk("regrant_dones", 32'(n_done - db), 1);
    chk("regrant_done_vec", 32'(last_done), 32'h2);
    chk("regrant_err", 32'(n_err_done + n_err_alone - eb), 0);
`ifdef KALMAN_MM_TIMEOUT_EN
    chk("abort_idle", 32'(mm_abort_o), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
